// File: rtl/rca_operand_sequencer_if.sv
// Handshake and adder-drive bundle for rca_operand_sequencer.
// slave  : the sequencer's view (consumes operands, drives the adder, produces results).
// master : the surrounding environment's view (upstream source, adder, downstream sink).
interface rca_operand_sequencer_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH-1:0] add_s;
  logic             add_co;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             busy;
  logic [7:0]       op_count;
  logic             chk_err;

  modport slave (
    input  in_valid, in_a, in_b, in_ci, add_s, add_co, out_ready,
    output in_ready, add_a, add_b, add_ci, out_valid, out_sum, out_co,
           busy, op_count, chk_err
  );

  modport master (
    output in_valid, in_a, in_b, in_ci, add_s, add_co, out_ready,
    input  in_ready, add_a, add_b, add_ci, out_valid, out_sum, out_co,
           busy, op_count, chk_err
  );
endinterface

// File: rtl/rca_operand_sequencer.sv
// Sequencer wrapped around an external ripple-carry adder: registers operands
// onto the adder inputs, waits SETTLE_CYCLES edges for the carry chain to
// settle, then captures sum/carry into a held result stream.
// Optional build macro RCA_SEQ_SELF_CHECK_EN adds a behavioural cross-check
// of the captured adder output that raises a sticky chk_err.
module rca_operand_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  rca_operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("rca_operand_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  state_t           state, state_n;
  logic             accept, capture, retire;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] add_a_p0, add_b_p0;
  logic             add_ci_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             co_p1;
  logic             vld_p1;
  logic [7:0]       op_count_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake strobes
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && !rst) begin
          accept  = 1'b1;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          capture = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          retire  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage 0: operand launch onto the adder; held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_p0  <= '0;
      add_b_p0  <= '0;
      add_ci_p0 <= 1'b0;
    end else if (accept) begin
      add_a_p0  <= bus.in_a;
      add_b_p0  <= bus.in_b;
      add_ci_p0 <= bus.in_ci;
    end
  end

  // Settle counter covering the ripple delay
  always_ff @(posedge clk) begin
    if (rst)                               cnt <= 4'd0;
    else if (accept)                       cnt <= CNT_INIT;
    else if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Stage 1: result capture and hold until the downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1 <= '0;
      co_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (capture) begin
      sum_p1 <= bus.add_s;
      co_p1  <= bus.add_co;
      vld_p1 <= 1'b1;
    end else if (retire) begin
      vld_p1 <= 1'b0;
    end
  end

  // Completed-transaction counter, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst)         op_count_q <= 8'd0;
    else if (retire) op_count_q <= op_count_q + 8'd1;
  end

`ifdef RCA_SEQ_SELF_CHECK_EN
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             ci);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  endfunction

  logic chk_err_q;

  // Sticky flag when the adder output disagrees with the reference sum
  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else if (capture && (ref_sum(add_a_p0, add_b_p0, add_ci_p0) != {bus.add_co, bus.add_s}))
      chk_err_q <= 1'b1;
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.add_a     = add_a_p0;
  assign bus.add_b     = add_b_p0;
  assign bus.add_ci    = add_ci_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_sum   = sum_p1;
  assign bus.out_co    = co_p1;
  assign bus.op_count  = op_count_q;

endmodule
